// File: rtl/fetch_unit_pkg.sv
// Shared core parameters and fetch-path types.
// Imported by the fetch unit, its queue and its interface.
package fetch_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned INSTR_BYTES = ILEN / 8;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [1:0] fq_count_t;
  localparam fq_count_t FQ_DEPTH = 2'd2;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input and decode handshake.
// master = fetch unit side, slave = memory/control/decode side.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int unsigned IMEM_AW = 12
) ();

  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [ILEN-1:0]    imem_rdata;
  logic               redirect;
  logic [XLEN-1:0]    redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [ILEN-1:0]    instr;
  logic [XLEN-1:0]    instr_pc;

  modport master (
    output imem_en, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_en, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, redirect, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// Two-entry in-order instruction queue; entry0 is always the head.
// Flush empties it outright and takes priority over push/pop.
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fq_count_t    count,
  output fetch_entry_t head
);

  fetch_entry_t entry0_q, entry0_d;
  fetch_entry_t entry1_q, entry1_d;
  fq_count_t    count_q, count_d;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == '0) entry0_d = push_entry;
          else               entry1_d = push_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          entry0_d = entry1_q;
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: shift behind the new head so order is kept.
          if (count_q == FQ_DEPTH) begin
            entry0_d = entry1_q;
            entry1_d = push_entry;
          end else begin
            entry0_d = push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= '0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = entry0_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, read issue against a 1-cycle BRAM, redirect handling,
// and a 2-entry queue feeding decode with a valid/ready handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     IMEM_AW  = 12
) (
  input  logic         clk,
  input  logic         rstn,
  fetch_unit_if.master fif
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

  fq_count_t       fq_count;
  fetch_entry_t    fq_head;
  fetch_entry_t    push_entry;
  fq_count_t       occupancy;
  logic            transfer;
  logic            push;
  logic            issue_en;
  logic [XLEN-1:0] issue_pc;

  always_comb begin
    transfer  = (fq_count != '0) && fif.instr_ready;
    // count + inflight never exceeds the queue depth, so issuing below it cannot overflow.
    occupancy = fq_count + fq_count_t'(inflight_q);
    issue_pc  = pc_q;
    issue_en  = 1'b0;
    if (rstn) begin
      if (fif.redirect) begin
        issue_pc = word_align(fif.redirect_pc);
        issue_en = 1'b1;
      end else if ((occupancy < FQ_DEPTH) || transfer) begin
        issue_en = 1'b1;
      end
    end
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (issue_en) begin
      pc_d          = issue_pc + XLEN'(INSTR_BYTES);
      inflight_d    = 1'b1;
      inflight_pc_d = issue_pc;
    end
  end

  // Data returning in a redirect cycle belongs to the abandoned stream.
  assign push       = inflight_q && !fif.redirect;
  assign push_entry = '{instr: fif.imem_rdata, pc: inflight_pc_q};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rstn       (rstn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (transfer),
    .flush      (fif.redirect),
    .count      (fq_count),
    .head       (fq_head)
  );

  assign fif.imem_en     = issue_en;
  assign fif.imem_addr   = issue_pc[IMEM_AW+1:2];
  assign fif.instr_valid = (fq_count != '0);
  assign fif.instr       = fq_head.instr;
  assign fif.instr_pc    = fq_head.pc;

endmodule
